// File: rtl/ifetch_unit_if.sv
// Interface bundle for ifetch_unit: instruction-memory req/ack, redirect input,
// decode-side valid/ready handshake, fault flag and performance counters.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        fetch_fault;
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect_valid, redirect_pc,
    output instr_valid, instr, instr_pc,
    input  instr_ready,
    output fetch_fault, perf_fetched, perf_flushed
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect_valid, redirect_pc,
    input  instr_valid, instr, instr_pc,
    output instr_ready,
    input  fetch_fault, perf_fetched, perf_flushed
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one request at a time to imem,
// buffers {word, pc} in a small FIFO. Optional counters enabled by IFETCH_PERF_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  ifetch_unit_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_FAULT} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             req_q, req_d;
  logic [31:0]      addr_q, addr_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [31:0]      instr_mem_q [FIFO_DEPTH];
  logic [31:0]      instr_mem_d [FIFO_DEPTH];
  logic [31:0]      pc_mem_q    [FIFO_DEPTH];
  logic [31:0]      pc_mem_d    [FIFO_DEPTH];

  logic             ack_seen;
  logic             push;
  logic             pop;
  logic             misaligned;
  logic [CNT_W-1:0] count_after;

  // An ack only counts while a request is actually on the bus.
  assign ack_seen    = bus.imem_ack && req_q;
  assign push        = (state_q == S_WAIT) && ack_seen && !bus.redirect_valid;
  assign pop         = (count_q != '0) && bus.instr_ready && !bus.redirect_valid;
  assign misaligned  = |bus.redirect_pc[1:0];
  assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    fault_d     = fault_q;
    count_d     = count_after;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    if (push) begin
      instr_mem_d[wptr_q] = bus.imem_rdata;
      pc_mem_d[wptr_q]    = addr_q;
      wptr_d              = wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (count_q < DEPTH_C) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      S_WAIT: begin
        if (ack_seen) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          // Chain the next request only if its response is guaranteed a slot.
          if (count_after < DEPTH_C) begin
            addr_d = fetch_pc_q + 32'd4;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (ack_seen) begin
          state_d = fault_q ? S_FAULT : S_IDLE;
          req_d   = 1'b0;
        end
      end
      S_FAULT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (bus.redirect_valid) begin
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
      fetch_pc_d = bus.redirect_pc;
      fault_d    = misaligned;
      // A killed request still in flight must be drained before anything else.
      if ((state_q == S_WAIT || state_q == S_DRAIN) && !ack_seen) begin
        state_d = S_DRAIN;
        req_d   = 1'b1;
        addr_d  = addr_q;
      end else begin
        state_d = misaligned ? S_FAULT : S_IDLE;
        req_d   = 1'b0;
        addr_d  = addr_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fault_q    <= 1'b0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fault_q    <= fault_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Buffer storage needs no reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr       = (count_q != '0) ? instr_mem_q[rptr_q] : 32'h0;
  assign bus.instr_pc    = (count_q != '0) ? pc_mem_q[rptr_q] : 32'h0;
  assign bus.fetch_fault = fault_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;

  // A redirect counts as a flush only if it threw away buffered or in-flight work.
  always_comb begin
    perf_fetched_d = perf_fetched_q + (push ? 32'd1 : 32'd0);
    perf_flushed_d = perf_flushed_q;
    if (bus.redirect_valid && ((count_q != '0) || (state_q == S_WAIT))) begin
      perf_flushed_d = perf_flushed_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 32'h0;
      perf_flushed_q <= 32'h0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign bus.perf_fetched = perf_fetched_q;
  assign bus.perf_flushed = perf_flushed_q;
`else
  assign bus.perf_fetched = 32'h0;
  assign bus.perf_flushed = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard testbench for ifetch_unit: directed phases push expected {pc, word}
// into a queue, monitors pop and compare on every accepted instruction.
module tb_ifetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic clk;
  logic rst;
  logic rst2;

  ifetch_unit_if bus ();
  ifetch_unit_if bus2 ();

  ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_dut_wrap (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  exp_t exp_q[$];
  exp_t exp_q2[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int grant, used, grant2, used2;
  int ack_delay;
  int ack_count;
  bit check_gap;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cycle++;
  end

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5EED_C0DE;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Queue the words the consumer should see and let memory answer that many acks (plus extra for drains).
  task automatic applyStimulus(input logic [31:0] start_pc, input int n_words, input int extra);
    exp_t e;
    for (int i = 0; i < n_words; i++) begin
      e.pc   = start_pc + 32'(4 * i);
      e.word = memWord(e.pc);
      exp_q.push_back(e);
    end
    grant += n_words + extra;
  endtask

  task automatic waitDrain(input string name, input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(negedge clk);
      k++;
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Memory model for the main DUT: acks after ack_delay cycles, limited by granted budget.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    used = 0;
    ack_count = 0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      #1;
      if (rst || !bus.imem_req) begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'hBAD0_BAD0;
        wait_cnt = 0;
      end else if ((grant - used) > 0 && wait_cnt >= ack_delay) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = memWord(bus.imem_addr);
        used++;
        ack_count++;
        wait_cnt = 0;
      end else begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'hBAD0_BAD0;
        if ((grant - used) > 0) wait_cnt++;
      end
    end
  end

  initial begin
    used2 = 0;
    bus2.imem_ack = 1'b0;
    bus2.imem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst2 && bus2.imem_req && (grant2 - used2) > 0) begin
        bus2.imem_ack = 1'b1;
        bus2.imem_rdata = memWord(bus2.imem_addr);
        used2++;
      end else begin
        bus2.imem_ack = 1'b0;
        bus2.imem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: a redirect in the same cycle cancels the pop, so it is not a handshake.
  initial begin
    exp_t e;
    bit armed;
    int last;
    armed = 1'b0;
    last = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_instr: got pc 0x%08h, expected no instruction", bus.instr_pc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("instr_pc", bus.instr_pc, e.pc);
          checkOutput("instr", bus.instr, e.word);
        end
        if (check_gap && armed) checkOutput("stream_gap", 32'(cycle - last), 32'd1);
        armed = check_gap;
        last = cycle;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst2 && bus2.instr_valid && bus2.instr_ready) begin
        if (exp_q2.size() != 0) begin
          e = exp_q2.pop_front();
          checkOutput("wrap_instr_pc", bus2.instr_pc, e.pc);
          checkOutput("wrap_instr", bus2.instr, e.word);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int k;
    int acks_base;
    rst = 1'b1;
    rst2 = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = 32'h0;
    bus2.instr_ready = 1'b1;
    grant = 0;
    grant2 = 0;
    ack_delay = 0;
    check_gap = 1'b0;

    // Reset values on both instances
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("rst_imem_addr", bus.imem_addr, 32'h0);
    checkOutput("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("rst_instr", bus.instr, 32'h0);
    checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
    checkOutput("rst_fetch_fault", 32'(bus.fetch_fault), 32'd0);
    checkOutput("rst_wrap_imem_addr", bus2.imem_addr, 32'hFFFF_FFF8);
    checkOutput("rst_wrap_imem_req", 32'(bus2.imem_req), 32'd0);

    // Streaming with combinational ack and ready held high
    @(negedge clk);
    applyStimulus(32'h0, 3, 0);
    check_gap = 1'b1;
    rst = 1'b0;
    waitDrain("stream_drain", 30);
    check_gap = 1'b0;
    #2;
    checkOutput("stream_next_req", 32'(bus.imem_req), 32'd1);
    checkOutput("stream_next_addr", bus.imem_addr, 32'hC);

    // Backpressure: only FIFO_DEPTH pushes, then fetch stops until ready returns
    bus.instr_ready = 1'b0;
    doReset();
    applyStimulus(32'h0, 3, 0);
    acks_base = ack_count;
    repeat (10) @(negedge clk);
    #2;
    checkOutput("bp_pushes", 32'(ack_count - acks_base), 32'd2);
    checkOutput("bp_imem_req", 32'(bus.imem_req), 32'd0);
    checkOutput("bp_instr_valid", 32'(bus.instr_valid), 32'd1);
    checkOutput("bp_head_pc", bus.instr_pc, 32'h0);
    checkOutput("bp_head_instr", bus.instr, memWord(32'h0));
    @(negedge clk);
    bus.instr_ready = 1'b1;
    waitDrain("bp_drain", 30);

    // Redirect while a request is outstanding; the late ack must be dropped
    doReset();
    applyStimulus(32'h0, 4, 0);
    waitDrain("pre_redirect_drain", 30);
    #2;
    checkOutput("pre_redirect_addr", bus.imem_addr, 32'h10);
    @(negedge clk);
    ack_delay = 3;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h100;
    applyStimulus(32'h100, 2, 1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #2;
    checkOutput("drain_imem_req", 32'(bus.imem_req), 32'd1);
    checkOutput("drain_imem_addr", bus.imem_addr, 32'h10);
    checkOutput("drain_instr_valid", 32'(bus.instr_valid), 32'd0);
    waitDrain("redirect_drain", 60);

    // Misaligned redirect: drain first, fault raised at once, then halted
    @(negedge clk);
    ack_delay = 2;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h102;
    applyStimulus(32'h102, 0, 1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #2;
    checkOutput("fault_immediate", 32'(bus.fetch_fault), 32'd1);
    checkOutput("fault_drain_req", 32'(bus.imem_req), 32'd1);
    repeat (10) @(negedge clk);
    #2;
    checkOutput("fault_held", 32'(bus.fetch_fault), 32'd1);
    checkOutput("fault_no_req", 32'(bus.imem_req), 32'd0);
    checkOutput("fault_no_valid", 32'(bus.instr_valid), 32'd0);
    @(negedge clk);
    ack_delay = 0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h200;
    applyStimulus(32'h200, 2, 0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #2;
    checkOutput("fault_cleared", 32'(bus.fetch_fault), 32'd0);
    waitDrain("fault_recover_drain", 30);

    // Redirect coinciding with ack and pop: nothing stale survives
    bus.instr_ready = 1'b0;
    doReset();
    applyStimulus(32'h0, 0, 1);
    repeat (4) @(negedge clk);
    #2;
    checkOutput("coinc_pre_valid", 32'(bus.instr_valid), 32'd1);
    checkOutput("coinc_pre_addr", bus.imem_addr, 32'h4);
    @(negedge clk);
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h300;
    applyStimulus(32'h300, 2, 1);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #2;
    checkOutput("coinc_flushed_valid", 32'(bus.instr_valid), 32'd0);
    checkOutput("coinc_idle_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    #2;
    checkOutput("coinc_new_req", 32'(bus.imem_req), 32'd1);
    checkOutput("coinc_new_addr", bus.imem_addr, 32'h300);
    waitDrain("coinc_drain", 30);
    #2;
`ifdef IFETCH_PERF_EN
    checkOutput("perf_fetched_main", bus.perf_fetched, 32'd3);
    checkOutput("perf_flushed_main", bus.perf_flushed, 32'd1);
`else
    checkOutput("perf_fetched_tied", bus.perf_fetched, 32'd0);
    checkOutput("perf_flushed_tied", bus.perf_flushed, 32'd0);
`endif

    // PC wrap from RESET_PC = 0xFFFF_FFF8 on the second instance
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      e.pc   = 32'hFFFF_FFF8 + 32'(4 * i);
      e.word = memWord(e.pc);
      exp_q2.push_back(e);
    end
    grant2 = 3;
    rst2 = 1'b0;
    k = 0;
    while (exp_q2.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end
    checkOutput("wrap_drain", 32'(exp_q2.size()), 32'd0);
    #2;
`ifdef IFETCH_PERF_EN
    checkOutput("perf_fetched_wrap", bus2.perf_fetched, 32'd3);
`else
    checkOutput("perf_fetched_wrap_tied", bus2.perf_fetched, 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
